// File: rtl/hazard_stall_unit_pkg.sv
// Shared pipeline definitions for the hazard/forwarding blocks.
// Tnew: cycles from EX entry until a writer's result exists.
// Tuse: cycles from ID until a reader actually needs its source.
package pipe_defs;
  localparam int TNEW_NONE = 0;
  localparam int TNEW_ALU  = 1;
  localparam int TNEW_LOAD = 2;

  localparam int TUSE_ID   = 0;
  localparam int TUSE_EX   = 1;
  localparam int TUSE_MEM  = 2;

  localparam int REG_ZERO  = 0;

  // Writer slots tracked after ID: EX, MEM, WB (youngest first)
  localparam int NSLOT     = 3;
endpackage

// File: rtl/hazard_stall_unit_if.sv
// ID-stage request / stall control / per-stage writer info bundle.
//   slave  : the hazard unit (consumes ID fields, drives stall + slots)
//   master : the pipeline / testbench side
interface hazard_stall_unit_if #(
  parameter int REG_W = 5,
  parameter int T_W   = 2,
  parameter int CNT_W = 32
);
  logic             id_valid;
  logic [REG_W-1:0] rs_ID, rt_ID, rd_ID;
  logic [T_W-1:0]   tuse_rs_ID, tuse_rt_ID, tnew_ID;
  logic             use_rs_ID, use_rt_ID;

  logic             stall, pc_en, ifid_en, idex_clr;
  logic [REG_W-1:0] rd_EX, rd_MEM, rd_WB;
  logic [T_W-1:0]   tnew_EX, tnew_MEM, tnew_WB;
  logic [CNT_W-1:0] stall_count;

  modport slave (
    input  id_valid, rs_ID, rt_ID, rd_ID, tuse_rs_ID, tuse_rt_ID, tnew_ID,
           use_rs_ID, use_rt_ID,
    output stall, pc_en, ifid_en, idex_clr, rd_EX, rd_MEM, rd_WB,
           tnew_EX, tnew_MEM, tnew_WB, stall_count
  );

  modport master (
    output id_valid, rs_ID, rt_ID, rd_ID, tuse_rs_ID, tuse_rt_ID, tnew_ID,
           use_rs_ID, use_rt_ID,
    input  stall, pc_en, ifid_en, idex_clr, rd_EX, rd_MEM, rd_WB,
           tnew_EX, tnew_MEM, tnew_WB, stall_count
  );
endinterface

// File: rtl/hazard_stall_unit_slot.sv
// One in-flight writer slot {rd, tnew}.
//   clk, reset   : clock, synchronous active-high reset
//   i_bubble     : load an empty slot instead of the input writer
//   i_rd, i_tnew : writer entering this slot
//   o_rd, o_tnew : registered slot contents
//   o_tnew_dec   : tnew as the next slot should see it (saturating -1)
module hazard_slot #(
  parameter int REG_W = 5,
  parameter int T_W   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_bubble,
  input  logic [REG_W-1:0] i_rd,
  input  logic [T_W-1:0]   i_tnew,
  output logic [REG_W-1:0] o_rd,
  output logic [T_W-1:0]   o_tnew,
  output logic [T_W-1:0]   o_tnew_dec
);
  logic [REG_W-1:0] r_rd;
  logic [T_W-1:0]   r_tnew;

  always_ff @(posedge clk) begin
    if (reset || i_bubble) begin
      r_rd   <= '0;
      r_tnew <= '0;
    end else begin
      r_rd   <= i_rd;
      r_tnew <= i_tnew;
    end
  end

  assign o_rd       = r_rd;
  assign o_tnew     = r_tnew;
  // Tnew bottoms out at 0 once the result exists; never wraps.
  assign o_tnew_dec = (r_tnew == '0) ? '0 : r_tnew - T_W'(1);
endmodule

// File: rtl/hazard_stall_unit.sv
// Producer-side hazard detection for the 5-stage pipeline.
// Tracks writers in EX/MEM/WB with their remaining Tnew and stalls ID
// when a source would be needed before any forwarding path can supply it.
//   clk, reset : clock, synchronous active-high reset
//   bus        : ID request in; stall controls, per-stage rd/tnew and the
//                saturating stall-cycle counter out
module hazard_stall_unit
  import pipe_defs::*;
#(
  parameter int REG_W = 5,
  parameter int T_W   = 2,
  parameter int CNT_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  hazard_stall_unit_if.slave  bus
);
  logic [NSLOT-1:0][REG_W-1:0] w_rd, w_in_rd;
  logic [NSLOT-1:0][T_W-1:0]   w_tn, w_tn_dec, w_in_tn;
  logic [NSLOT-1:0]            w_bub;
  logic                        w_hz_rs, w_hz_rt, w_stall;
  logic [CNT_W-1:0]            r_stall_count;

  // Slot 0 (EX) takes the ID instruction unless it is held or a bubble;
  // the older slots always shift forward, even during a stall.
  assign w_in_rd[0] = bus.rd_ID;
  assign w_in_tn[0] = bus.tnew_ID;
  assign w_bub[0]   = w_stall | ~bus.id_valid;

  for (genvar i = 0; i < NSLOT; i++) begin : g_slot
    if (i > 0) begin : g_shift
      assign w_in_rd[i] = w_rd[i-1];
      assign w_in_tn[i] = w_tn_dec[i-1];
      assign w_bub[i]   = 1'b0;
    end
    hazard_slot #(.REG_W(REG_W), .T_W(T_W)) u_slot (
      .clk        (clk),
      .reset      (reset),
      .i_bubble   (w_bub[i]),
      .i_rd       (w_in_rd[i]),
      .i_tnew     (w_in_tn[i]),
      .o_rd       (w_rd[i]),
      .o_tnew     (w_tn[i]),
      .o_tnew_dec (w_tn_dec[i])
    );
  end

  // Only the youngest writer of a register matters: an older one is
  // overwritten by it and will never be forwarded for this source.
  function automatic logic src_hazard(
    input logic                        q,
    input logic [REG_W-1:0]            s,
    input logic [T_W-1:0]              tuse,
    input logic [NSLOT-1:0][REG_W-1:0] rd,
    input logic [NSLOT-1:0][T_W-1:0]   tn
  );
    logic hit, found;
    hit   = 1'b0;
    found = 1'b0;
    for (int i = 0; i < NSLOT; i++) begin
      if (!found && rd[i] == s) begin
        found = 1'b1;
        hit   = tn[i] > tuse;
      end
    end
    return q && (s != REG_W'(REG_ZERO)) && hit;
  endfunction

  assign w_hz_rs = src_hazard(bus.id_valid & bus.use_rs_ID, bus.rs_ID,
                              bus.tuse_rs_ID, w_rd, w_tn);
  assign w_hz_rt = src_hazard(bus.id_valid & bus.use_rt_ID, bus.rt_ID,
                              bus.tuse_rt_ID, w_rd, w_tn);
  assign w_stall = ~reset & (w_hz_rs | w_hz_rt);

  always_ff @(posedge clk) begin
    if (reset)
      r_stall_count <= '0;
    else if (w_stall && !(&r_stall_count))
      r_stall_count <= r_stall_count + CNT_W'(1);
  end

  assign bus.stall       = w_stall;
  assign bus.pc_en       = ~w_stall;
  assign bus.ifid_en     = ~w_stall;
  assign bus.idex_clr    = w_stall;
  assign bus.rd_EX       = w_rd[0];
  assign bus.rd_MEM      = w_rd[1];
  assign bus.rd_WB       = w_rd[2];
  assign bus.tnew_EX     = w_tn[0];
  assign bus.tnew_MEM    = w_tn[1];
  assign bus.tnew_WB     = w_tn[2];
  assign bus.stall_count = r_stall_count;
endmodule

// File: tb/tb_hazard_stall_unit.sv
module tb_hazard_stall_unit;
  import pipe_defs::*;

  localparam int REG_W = 5;
  localparam int T_W   = 2;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_stall_unit_if #(.REG_W(REG_W), .T_W(T_W), .CNT_W(CNT_W)) bus ();

  hazard_stall_unit #(.REG_W(REG_W), .T_W(T_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit v; int rs; int rt; int tus; int tut; bit urs; bit urt; int rd; int tn;
  } instr_t;

  typedef struct { int rd; int tn; } wr_t;

  typedef struct {
    bit stall; int rd[3]; int tn[3]; int cnt;
  } exp_t;

  exp_t expq[$];
  wr_t  pipe[$];   // in-flight writers, youngest at index 0
  int   m_cnt;
  int   checks = 0;
  int   errors = 0;

  function automatic instr_t mk(bit v, int rs, int rt, int tus, int tut,
                                bit urs, bit urt, int rd, int tn);
    instr_t r;
    r.v = v; r.rs = rs; r.rt = rt; r.tus = tus; r.tut = tut;
    r.urs = urs; r.urt = urt; r.rd = rd; r.tn = tn;
    return r;
  endfunction

  // A source must wait if its most recent pending writer will not have
  // produced the value by the time the reader needs it.
  function automatic bit needs_wait(bit q, int s, int tuse);
    if (!q || s == REG_ZERO) return 1'b0;
    foreach (pipe[i])
      if (pipe[i].rd == s) return pipe[i].tn > tuse;
    return 1'b0;
  endfunction

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endfunction

  task automatic step(input bit rst, input instr_t in, output bit st);
    exp_t e;
    wr_t  nw;
    reset          = rst;
    bus.id_valid   = in.v;
    bus.rs_ID      = REG_W'(in.rs);
    bus.rt_ID      = REG_W'(in.rt);
    bus.tuse_rs_ID = T_W'(in.tus);
    bus.tuse_rt_ID = T_W'(in.tut);
    bus.use_rs_ID  = in.urs;
    bus.use_rt_ID  = in.urt;
    bus.rd_ID      = REG_W'(in.rd);
    bus.tnew_ID    = T_W'(in.tn);
    st = !rst && (needs_wait(in.v && in.urs, in.rs, in.tus) ||
                  needs_wait(in.v && in.urt, in.rt, in.tut));
    e.stall = st;
    for (int i = 0; i < 3; i++) begin
      e.rd[i] = pipe[i].rd;
      e.tn[i] = pipe[i].tn;
    end
    e.cnt = m_cnt;
    expq.push_back(e);
    if (rst) begin
      foreach (pipe[i]) pipe[i] = '{0, 0};
      m_cnt = 0;
    end else begin
      // every writer ages one cycle; the oldest retires
      foreach (pipe[i]) pipe[i].tn = (pipe[i].tn > 0) ? pipe[i].tn - 1 : 0;
      nw = (st || !in.v) ? '{0, 0} : '{in.rd, in.tn};
      pipe.push_front(nw);
      void'(pipe.pop_back());
      if (st && m_cnt < CMAX) m_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  // Present an instruction and keep it held in ID while it stalls.
  task automatic issue(input instr_t in, input bit rnd_rst);
    bit st, r;
    int g = 0;
    do begin
      r = rnd_rst && ($urandom_range(0, 149) == 0);
      step(r, in, st);
      g++;
    end while (st && g < 8);
  endtask

  task automatic nops(input int n);
    bit st;
    repeat (n) step(1'b0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0), st);
  endtask

  // Monitor: one expected record per cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("stall",       bus.stall,       32'(e.stall));
        chk("pc_en",       bus.pc_en,       32'(!e.stall));
        chk("ifid_en",     bus.ifid_en,     32'(!e.stall));
        chk("idex_clr",    bus.idex_clr,    32'(e.stall));
        chk("rd_EX",       bus.rd_EX,       32'(e.rd[0]));
        chk("rd_MEM",      bus.rd_MEM,      32'(e.rd[1]));
        chk("rd_WB",       bus.rd_WB,       32'(e.rd[2]));
        chk("tnew_EX",     bus.tnew_EX,     32'(e.tn[0]));
        chk("tnew_MEM",    bus.tnew_MEM,    32'(e.tn[1]));
        chk("tnew_WB",     bus.tnew_WB,     32'(e.tn[2]));
        chk("stall_count", bus.stall_count, 32'(e.cnt));
      end
    end
  end

  initial begin
    bit st;
    instr_t beq8;
    // first edge brings the DUT out of its unknown power-up state
    reset = 1'b1;
    bus.id_valid = 1'b1; bus.rs_ID = '0; bus.rt_ID = '0; bus.rd_ID = 5'd5;
    bus.tnew_ID = 2'd2; bus.tuse_rs_ID = '0; bus.tuse_rt_ID = '0;
    bus.use_rs_ID = 1'b0; bus.use_rt_ID = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) pipe.push_back('{0, 0});
    m_cnt = 0;

    // reset held with a live writer in ID: everything stays zero
    step(1'b1, mk(1, 0, 0, 0, 0, 0, 0, 5, TNEW_LOAD), st);
    nops(2);

    // lw $8 ; add rs=8 (Tuse 1) -> one stall
    issue(mk(1, 0, 0, 0, 0, 0, 0, 8, TNEW_LOAD), 0);
    issue(mk(1, 8, 0, TUSE_EX, TUSE_EX, 1, 0, 10, TNEW_ALU), 0);
    nops(3);

    // add $9 ; beq rs=9 (Tuse 0) -> one stall
    issue(mk(1, 0, 0, 0, 0, 0, 0, 9, TNEW_ALU), 0);
    issue(mk(1, 9, 0, TUSE_ID, TUSE_ID, 1, 0, 0, TNEW_NONE), 0);
    nops(3);
    // lw $9 ; beq -> two stalls
    issue(mk(1, 0, 0, 0, 0, 0, 0, 9, TNEW_LOAD), 0);
    issue(mk(1, 9, 0, TUSE_ID, TUSE_ID, 1, 0, 0, TNEW_NONE), 0);
    nops(3);

    // shadowing: lw $4 then add $4; consumer rs=4 Tuse 1 sees the add
    issue(mk(1, 0, 0, 0, 0, 0, 0, 4, TNEW_LOAD), 0);
    issue(mk(1, 0, 0, 0, 0, 0, 0, 4, TNEW_ALU), 0);
    issue(mk(1, 4, 0, TUSE_EX, TUSE_EX, 1, 0, 11, TNEW_ALU), 0);
    nops(3);

    // $0 never hazards; an unused source never hazards
    issue(mk(1, 0, 0, 0, 0, 0, 0, 0, TNEW_LOAD), 0);
    issue(mk(1, 0, 0, TUSE_ID, TUSE_ID, 1, 1, 12, TNEW_ALU), 0);
    issue(mk(1, 0, 0, 0, 0, 0, 0, 7, TNEW_LOAD), 0);
    issue(mk(1, 7, 7, TUSE_ID, TUSE_ID, 0, 0, 13, TNEW_ALU), 0);
    nops(3);

    // two sources hazarding on different producers
    issue(mk(1, 0, 0, 0, 0, 0, 0, 2, TNEW_LOAD), 0);
    issue(mk(1, 0, 0, 0, 0, 0, 0, 3, 3), 0);
    issue(mk(1, 2, 3, TUSE_ID, TUSE_ID, 1, 1, 14, TNEW_ALU), 0);
    nops(3);

    // reset in the middle of the lw/beq two-cycle stall
    beq8 = mk(1, 8, 0, TUSE_ID, TUSE_ID, 1, 0, 0, TNEW_NONE);
    issue(mk(1, 0, 0, 0, 0, 0, 0, 8, TNEW_LOAD), 0);
    step(1'b0, beq8, st);
    step(1'b1, beq8, st);
    step(1'b0, beq8, st);
    nops(3);

    // counter saturation: repeated 3-cycle stalls without reset
    repeat (8) begin
      issue(mk(1, 0, 0, 0, 0, 0, 0, 6, 3), 0);
      issue(mk(1, 6, 0, TUSE_ID, TUSE_ID, 1, 0, 0, TNEW_NONE), 0);
    end
    nops(3);

    // randomized traffic with occasional reset
    repeat (400) begin
      issue(mk($urandom_range(0, 7) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
               $urandom_range(0, 2), $urandom_range(0, 2),
               $urandom_range(0, 1), $urandom_range(0, 1),
               $urandom_range(0, 7), $urandom_range(0, 3)), 1);
    end
    nops(3);

    repeat (3) @(posedge clk);
    if (expq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d records left, expected 0", expq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Producer-side companion to the EX-stage forwarding selector in the 5-stage MIPS pipeline.
- Tracks each in-flight writer's destination register and remaining Tnew through the EX, MEM and WB slots, decrementing Tnew every cycle.
- Raises a stall when an ID-stage source cannot be satisfied by forwarding in time.
- Exports per-stage rd/Tnew, which the forwarding selector consumes.

Parameters:
- REG_W, 5, register-index width
- T_W, 2, Tnew/Tuse width
- CNT_W, 32, stall performance-counter width

Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction; 0 means bubble: no sources, no write
- rs_ID  in  REG_W  source 1 index
- rt_ID  in  REG_W  source 2 index
- tuse_rs_ID  in  T_W  cycles until rs is needed (0 = in ID)
- tuse_rt_ID  in  T_W  cycles until rt is needed
- use_rs_ID  in  1  instruction reads rs
- use_rt_ID  in  1  instruction reads rt
- rd_ID  in  REG_W  destination index, 0 = no write
- tnew_ID  in  T_W  cycles from EX entry until the result exists (ALU 1, load 2, link 0)
- stall  out  1  hazard detected
- pc_en  out  1  ~stall
- ifid_en  out  1  ~stall
- idex_clr  out  1  = stall; inject a bubble into ID/EX
- rd_EX  out  REG_W  EX slot destination
- rd_MEM  out  REG_W  MEM slot destination
- rd_WB  out  REG_W  WB slot destination
- tnew_EX  out  T_W  EX slot Tnew
- tnew_MEM  out  T_W  MEM slot Tnew
- tnew_WB  out  T_W  WB slot Tnew
- stall_count  out  CNT_W  number of stall cycles since reset

Behaviour:
- Slots: EX, MEM and WB each hold the registers {rd, tnew}.
- Reset (sync, at the posedge with reset=1): all slot rd=0, tnew=0; stall_count=0.
- While reset=1, stall is forced to 0 combinationally, so pc_en=ifid_en=1 and idex_clr=0.
- Advance on every posedge when not in reset:
  - WB <= {MEM.rd, sat_dec(MEM.tnew)}
  - MEM <= {EX.rd, sat_dec(EX.tnew)}
  - EX <= (stall | ~id_valid) ? {0,0} : {rd_ID, tnew_ID}
- sat_dec(x) = (x==0) ? 0 : x-1. It never wraps.
- MEM and WB advance during a stall. Only the ID instruction is held, and EX receives a bubble.
- Hazard test, per source s in {rs, rt}, is combinational with zero latency:
  - Qualifying conditions: id_valid & use_s & s!=0.
  - hit_X = (X.rd == s) & (X.tnew > tuse_s), for X in {EX, MEM, WB}.
  - Only the youngest stage with X.rd == s is evaluated. Priority is EX > MEM > WB, so an older writer of the same register is shadowed.
  - stall = OR of the youngest-match hits over rs and rt.
- rd==0 in a slot never matches, because $0 is excluded via s!=0.
- Cases:
  - Load in EX (tnew 2), consumer Tuse 1: stall exactly 1 cycle. The next cycle the load is in MEM with tnew 1, and the consumer proceeds.
  - Load in EX, consumer Tuse 0 (branch): 2 stall cycles.
  - ALU in EX (tnew 1), branch Tuse 0: 1 stall cycle.
  - Both sources hazard on different producers: a single stall signal, which persists until both clear.
- stall_count increments by 1 on each posedge where stall=1. It saturates at all-ones.
- Reset asserted mid-stall: slots clear at that edge. The held ID instruction is re-evaluated against empty slots afterwards and sees no stall.
- Outputs rd_*/tnew_* are direct register outputs with no combinational path from inputs.

Decomposition:
- Shared package pipe_defs:
  - Tnew constants: TNEW_NONE=0, TNEW_ALU=1, TNEW_LOAD=2
  - Tuse constants: TUSE_ID=0, TUSE_EX=1, TUSE_MEM=2
  - REG_ZERO=0
- Sub-module hazard_slot:
  - One {rd, tnew} register with sync reset, a load mux (bubble or input) and a saturating decrement on output.
  - Instantiated three times.

Test Plan:
- reset=1 for 2 cycles with id_valid=1, rd_ID=5, tnew_ID=2 -> all rd_*/tnew_*=0, stall=0, stall_count=0.
- lw $8 (rd 8, tnew 2), then add using rs=8 with tuse_rs 1 -> exactly one stall cycle: idex_clr=1 and EX rd=0 for that cycle. Next cycle rd_MEM=8 and tnew_MEM=1, stall=0; stall_count=1.
- add $9 (tnew 1), then beq rs=9 with tuse 0 -> one stall cycle. lw $9 then beq -> two stall cycles; stall_count +2.
- Shadowing: lw $4 in MEM (tnew 1) and add $4 in EX (tnew 1); consumer Tuse 1 on rs=4 -> no stall (the EX match wins, 1>1 is false).
- Zero register and no-use cases, each -> stall=0:
  - lw $0 then a consumer on rs=0.
  - use_rs_ID=0 with a matching rs.
- Preload stall_count near max (or run 2^CNT_W cycles with a reduced CNT_W=4) under a continuous stall -> stall_count holds at all-ones.
- Assert reset during the 2-cycle lw/beq stall -> the next cycle has stall=0 and all slots zero.
